// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants, address-width helper and default data types for the
// multi-port register file with busy-bit scoreboard.
package regfile_mp_sb_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_REGS = 32;

  // Address width needed to index num_regs registers (at least one bit).
  function automatic int addr_w(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  localparam int DEF_AW = addr_w(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]     reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bundle for the register file: read ports, write ports,
// reservation request and the busy counter.
interface regfile_mp_sb_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int AW = regfile_mp_sb_pkg::addr_w(NUM_REGS);

  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][AW-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          rsv_en;
  logic [AW-1:0]                 rsv_addr;
  logic [AW:0]                   busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_count
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, qualified writes clear it,
// a reservation beats a release of the same register in the same cycle.
// Also produces per-read-port busy flags and a registered popcount.
module regfile_mp_sb_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int AW       = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rsv_en_i,
  input  logic [AW-1:0]             rsv_addr_i,
  input  logic [NUM_WR-1:0]         wr_ok_i,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr_i,
  input  logic [NUM_RD-1:0]         rd_ok_i,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]         rd_busy_o,
  output logic [AW:0]               busy_count_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_s;
  logic                rsv_ok_s;
  logic [AW:0]         busy_count_q;
  logic [AW:0]         busy_count_d;

  // Reservations of the zero register or beyond the array are ignored
  always_comb begin
    rsv_ok_s = rsv_en_i && (int'(rsv_addr_i) < NUM_REGS) && (int'(rsv_addr_i) != ZERO_REG);
  end

  // Release vector: any qualified write port targeting the register
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_s[i] = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok_i[w] && (int'(wr_addr_i[w]) == i)) begin
          clr_s[i] = 1'b1;
        end else begin
          clr_s[i] = clr_s[i];
        end
      end
    end
  end

  // Next busy state: a new producer's reservation wins over a retiring write
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_ok_s && (int'(rsv_addr_i) == i)) begin
        busy_d[i] = 1'b1;
      end else if (clr_s[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Popcount of the next busy state so the counter matches the bits after the edge
  always_comb begin
    busy_count_d = {(AW+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // Busy bits and counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= {NUM_REGS{1'b0}};
      busy_count_q <= {(AW+1){1'b0}};
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Per-read busy flag; with forwarding, a register being written back now is not busy
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      if (!rd_ok_i[r]) begin
        rd_busy_o[r] = 1'b0;
      end else if (BYPASS != 0) begin
        rd_busy_o[r] = busy_q[rd_addr_i[r]] & ~clr_s[rd_addr_i[r]];
      end else begin
        rd_busy_o[r] = busy_q[rd_addr_i[r]];
      end
    end
  end

  assign busy_count_o = busy_count_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with hardwired zero register, highest-port-wins
// write priority, optional same-cycle write-to-read forwarding and an
// integrated busy-bit scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = NUM_REGS - 1,
  parameter int BYPASS   = 1
) (
  input logic            clk,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);

  localparam int AW = addr_w(NUM_REGS);

  typedef logic [AW-1:0]     addr_t;
  typedef logic [DATA_W-1:0] data_t;

  data_t                         regs_q [NUM_REGS];
  data_t                         regs_d [NUM_REGS];
  logic [NUM_WR-1:0]             wr_ok_s;
  logic [NUM_RD-1:0]             rd_ok_s;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]             rd_busy_s;
  logic [AW:0]                   busy_count_s;

  // Address names a real, writable register (not the zero register, not past the end)
  function automatic logic addr_valid(input addr_t a);
    return (int'(a) < NUM_REGS) && (int'(a) != ZERO_REG);
  endfunction

  // Qualify write ports; dropped writes neither store nor forward nor release
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok_s[w] = bus.wr_en[w] && addr_valid(bus.wr_addr[w]);
    end
  end

  // Qualify read ports; invalid addresses read as zero and never busy
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_ok_s[r] = addr_valid(bus.rd_addr[r]);
    end
  end

  // Next register contents; ports scanned upward so the highest index wins
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok_s[w] && (int'(bus.wr_addr[w]) == i)) begin
          regs_d[i] = bus.wr_data[w];
        end else begin
          regs_d[i] = regs_d[i];
        end
      end
    end
  end

  // Register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes with per (read, write) pair forwarding compare, same priority as storage
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_ok_s[r]) begin
        rd_data_s[r] = regs_q[bus.rd_addr[r]];
        for (int w = 0; w < NUM_WR; w++) begin
          if ((BYPASS != 0) && wr_ok_s[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
            rd_data_s[r] = bus.wr_data[w];
          end else begin
            rd_data_s[r] = rd_data_s[r];
          end
        end
      end else begin
        rd_data_s[r] = {DATA_W{1'b0}};
      end
    end
  end

  regfile_mp_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .rsv_en_i     (bus.rsv_en),
    .rsv_addr_i   (bus.rsv_addr),
    .wr_ok_i      (wr_ok_s),
    .wr_addr_i    (bus.wr_addr),
    .rd_ok_i      (rd_ok_s),
    .rd_addr_i    (bus.rd_addr),
    .rd_busy_o    (rd_busy_s),
    .busy_count_o (busy_count_s)
  );

  assign bus.rd_data    = rd_data_s;
  assign bus.rd_busy    = rd_busy_s;
  assign bus.busy_count = busy_count_s;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: default config with forwarding (u_a), same config without
// forwarding (u_b), and a 24-entry, 3-read, 1-write, 32-bit config (u_c).
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] D_VAL = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] A_VAL = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B_VAL = 64'h5555_6666_7777_8888;
  localparam logic [63:0] X_VAL = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Y_VAL = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  regfile_mp_sb_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus_b ();
  regfile_mp_sb_if #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(3), .NUM_WR(1)) bus_c ();

  regfile_mp_sb #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp_sb #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));
  regfile_mp_sb #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(3), .NUM_WR(1), .BYPASS(1))
    u_c (.clk(clk), .reset(reset), .bus(bus_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0; bus_a.rd_addr = '0;
    bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0; bus_b.rd_addr = '0;
    bus_c.wr_en = '0; bus_c.wr_addr = '0; bus_c.wr_data = '0; bus_c.rsv_en = 1'b0; bus_c.rsv_addr = '0; bus_c.rd_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus_a.wr_en = 2'b11; bus_a.wr_addr[0] = 5'(k); bus_a.wr_addr[1] = 5'(k + 10);
      bus_a.wr_data[0] = {$urandom, $urandom}; bus_a.wr_data[1] = {$urandom, $urandom};
      bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'(k + 1);
      bus_b.wr_en = 2'b11; bus_b.wr_addr[0] = 5'(k); bus_b.wr_addr[1] = 5'(k + 10);
      bus_b.wr_data[0] = {$urandom, $urandom}; bus_b.wr_data[1] = {$urandom, $urandom};
      bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'(k + 1);
      bus_c.wr_en = 1'b1; bus_c.wr_addr[0] = 5'(k); bus_c.wr_data[0] = $urandom;
      bus_c.rsv_en = 1'b1; bus_c.rsv_addr = 5'(k + 1);
      step();
    end
    // reset asserted while writes and reservations are still being driven
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_all();
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d expected 0", bus_a.busy_count); end
    n_checks++; if (bus_b.busy_count !== 6'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", bus_b.busy_count); end
    n_checks++; if (bus_c.busy_count !== 6'd0) begin n_fail++; $display("FAIL reset_count_c: got %0d expected 0", bus_c.busy_count); end
    for (int i = 0; i < 32; i++) begin
      bus_a.rd_addr[0] = 5'(i); bus_a.rd_addr[1] = 5'(31 - i);
      bus_b.rd_addr[0] = 5'(i); bus_b.rd_addr[1] = 5'(31 - i);
      bus_c.rd_addr[0] = 5'(i % 24);
      #1;
      n_checks++; if (bus_a.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL reset_read_a0 reg %0d: got %h expected 0", i, bus_a.rd_data[0]); end
      n_checks++; if (bus_a.rd_data[1] !== 64'h0) begin n_fail++; $display("FAIL reset_read_a1 reg %0d: got %h expected 0", 31 - i, bus_a.rd_data[1]); end
      n_checks++; if (bus_a.rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy_a reg %0d: got %b expected 00", i, bus_a.rd_busy); end
      n_checks++; if (bus_b.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL reset_read_b0 reg %0d: got %h expected 0", i, bus_b.rd_data[0]); end
      n_checks++; if (bus_c.rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL reset_read_c0 reg %0d: got %h expected 0", i % 24, bus_c.rd_data[0]); end
      step();
    end
  endtask

  task automatic test_bypass();
    bus_a.wr_en = 2'b01; bus_a.wr_addr[0] = 5'd5; bus_a.wr_data[0] = D_VAL; bus_a.rd_addr[0] = 5'd5;
    bus_b.wr_en = 2'b01; bus_b.wr_addr[0] = 5'd5; bus_b.wr_data[0] = D_VAL; bus_b.rd_addr[0] = 5'd5;
    #1;
    n_checks++; if (bus_a.rd_data[0] !== D_VAL) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", bus_a.rd_data[0], D_VAL); end
    n_checks++; if (bus_a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_nonbusy: got %b expected 0", bus_a.rd_busy[0]); end
    n_checks++; if (bus_b.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL nobypass_old_value: got %h expected 0", bus_b.rd_data[0]); end
    step();
    idle_all();
    bus_a.rd_addr[0] = 5'd5; bus_b.rd_addr[0] = 5'd5;
    #1;
    n_checks++; if (bus_b.rd_data[0] !== D_VAL) begin n_fail++; $display("FAIL nobypass_next_cycle: got %h expected %h", bus_b.rd_data[0], D_VAL); end
    n_checks++; if (bus_a.rd_data[0] !== D_VAL) begin n_fail++; $display("FAIL bypass_stored: got %h expected %h", bus_a.rd_data[0], D_VAL); end
    n_checks++; if (bus_a.busy_count !== 6'd0) begin n_fail++; $display("FAIL write_nonbusy_count: got %0d expected 0", bus_a.busy_count); end
  endtask

  task automatic test_conflict();
    step();
    bus_a.wr_en = 2'b11; bus_a.wr_addr[0] = 5'd7; bus_a.wr_addr[1] = 5'd7;
    bus_a.wr_data[0] = A_VAL; bus_a.wr_data[1] = B_VAL; bus_a.rd_addr[1] = 5'd7;
    bus_b.wr_en = 2'b11; bus_b.wr_addr[0] = 5'd7; bus_b.wr_addr[1] = 5'd7;
    bus_b.wr_data[0] = A_VAL; bus_b.wr_data[1] = B_VAL;
    #1;
    n_checks++; if (bus_a.rd_data[1] !== B_VAL) begin n_fail++; $display("FAIL conflict_bypass: got %h expected %h", bus_a.rd_data[1], B_VAL); end
    step();
    idle_all();
    bus_a.rd_addr[0] = 5'd7; bus_b.rd_addr[0] = 5'd7;
    #1;
    n_checks++; if (bus_a.rd_data[0] !== B_VAL) begin n_fail++; $display("FAIL conflict_store_a: got %h expected %h", bus_a.rd_data[0], B_VAL); end
    n_checks++; if (bus_b.rd_data[0] !== B_VAL) begin n_fail++; $display("FAIL conflict_store_b: got %h expected %h", bus_b.rd_data[0], B_VAL); end
  endtask

  task automatic test_zero_reg();
    step();
    bus_a.wr_en = 2'b01; bus_a.wr_addr[0] = 5'd31; bus_a.wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd31; bus_a.rd_addr[0] = 5'd31;
    #1;
    n_checks++; if (bus_a.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL zero_bypass: got %h expected 0", bus_a.rd_data[0]); end
    n_checks++; if (bus_a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy_same: got %b expected 0", bus_a.rd_busy[0]); end
    step();
    idle_all();
    bus_a.rd_addr[0] = 5'd31;
    #1;
    n_checks++; if (bus_a.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL zero_stored: got %h expected 0", bus_a.rd_data[0]); end
    n_checks++; if (bus_a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy_next: got %b expected 0", bus_a.rd_busy[0]); end
    n_checks++; if (bus_a.busy_count !== 6'd0) begin n_fail++; $display("FAIL zero_rsv_count: got %0d expected 0", bus_a.busy_count); end
  endtask

  task automatic test_scoreboard();
    step();
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd3;
    bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'd3;
    step();
    bus_a.rsv_addr = 5'd9; bus_b.rsv_addr = 5'd9;
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd1) begin n_fail++; $display("FAIL rsv_count_1: got %0d expected 1", bus_a.busy_count); end
    step();
    idle_all();
    bus_a.rd_addr[0] = 5'd3; bus_a.rd_addr[1] = 5'd9;
    bus_b.rd_addr[0] = 5'd3; bus_b.rd_addr[1] = 5'd9;
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd2) begin n_fail++; $display("FAIL rsv_count_2: got %0d expected 2", bus_a.busy_count); end
    n_checks++; if (bus_a.rd_busy !== 2'b11) begin n_fail++; $display("FAIL rsv_rd_busy_a: got %b expected 11", bus_a.rd_busy); end
    n_checks++; if (bus_b.rd_busy !== 2'b11) begin n_fail++; $display("FAIL rsv_rd_busy_b: got %b expected 11", bus_b.rd_busy); end
    step();
    // writeback of 3: forwarding sees the release, the pre-edge view does not
    bus_a.wr_en = 2'b01; bus_a.wr_addr[0] = 5'd3; bus_a.wr_data[0] = X_VAL;
    bus_b.wr_en = 2'b01; bus_b.wr_addr[0] = 5'd3; bus_b.wr_data[0] = X_VAL;
    #1;
    n_checks++; if (bus_a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL release_bypass_busy: got %b expected 0", bus_a.rd_busy[0]); end
    n_checks++; if (bus_a.rd_data[0] !== X_VAL) begin n_fail++; $display("FAIL release_bypass_data: got %h expected %h", bus_a.rd_data[0], X_VAL); end
    n_checks++; if (bus_b.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL release_nobypass_busy: got %b expected 1", bus_b.rd_busy[0]); end
    n_checks++; if (bus_b.rd_data[0] !== 64'h0) begin n_fail++; $display("FAIL release_nobypass_data: got %h expected 0", bus_b.rd_data[0]); end
    step();
    // writeback of 9 coincides with a new reservation of 9
    bus_a.wr_addr[0] = 5'd9; bus_a.wr_data[0] = Y_VAL; bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd9;
    bus_b.wr_addr[0] = 5'd9; bus_b.wr_data[0] = Y_VAL; bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'd9;
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd1) begin n_fail++; $display("FAIL release3_count: got %0d expected 1", bus_a.busy_count); end
    n_checks++; if (bus_b.busy_count !== 6'd1) begin n_fail++; $display("FAIL release3_count_b: got %0d expected 1", bus_b.busy_count); end
    step();
    // re-reserve 9 while already busy
    bus_a.wr_en = 2'b00; bus_b.wr_en = 2'b00;
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd1) begin n_fail++; $display("FAIL rsv_wins_count: got %0d expected 1", bus_a.busy_count); end
    n_checks++; if (bus_a.rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL rsv_wins_busy: got %b expected 1", bus_a.rd_busy[1]); end
    n_checks++; if (bus_a.rd_data[1] !== Y_VAL) begin n_fail++; $display("FAIL rsv_wins_data: got %h expected %h", bus_a.rd_data[1], Y_VAL); end
    step();
    // final release of 9 on write port 1
    bus_a.rsv_en = 1'b0; bus_a.wr_en = 2'b10; bus_a.wr_addr[1] = 5'd9; bus_a.wr_data[1] = A_VAL;
    bus_b.rsv_en = 1'b0; bus_b.wr_en = 2'b10; bus_b.wr_addr[1] = 5'd9; bus_b.wr_data[1] = A_VAL;
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd1) begin n_fail++; $display("FAIL rerserve_count: got %0d expected 1", bus_a.busy_count); end
    n_checks++; if (bus_a.rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL release_p1_bypass: got %b expected 0", bus_a.rd_busy[1]); end
    n_checks++; if (bus_b.rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL release_p1_nobypass: got %b expected 1", bus_b.rd_busy[1]); end
    step();
    idle_all();
    #1;
    n_checks++; if (bus_a.busy_count !== 6'd0) begin n_fail++; $display("FAIL final_count_a: got %0d expected 0", bus_a.busy_count); end
    n_checks++; if (bus_b.busy_count !== 6'd0) begin n_fail++; $display("FAIL final_count_b: got %0d expected 0", bus_b.busy_count); end
  endtask

  task automatic test_small_config();
    logic [31:0] exp_v;
    int          ad;
    for (int i = 0; i < 24; i++) begin
      step();
      bus_c.wr_en = 1'b1; bus_c.wr_addr[0] = 5'(i); bus_c.wr_data[0] = 32'hA500_0000 + 32'(i);
    end
    step();
    bus_c.wr_addr[0] = 5'd30; bus_c.wr_data[0] = 32'hFFFF_FFFF;
    step();
    idle_all();
    for (int i = 0; i < 23; i++) begin
      bus_c.rd_addr[0] = 5'(i); bus_c.rd_addr[1] = 5'(22 - i); bus_c.rd_addr[2] = 5'((i + 5) % 23);
      #1;
      for (int p = 0; p < 3; p++) begin
        ad    = (p == 0) ? i : ((p == 1) ? (22 - i) : ((i + 5) % 23));
        exp_v = 32'hA500_0000 + 32'(ad);
        n_checks++; if (bus_c.rd_data[p] !== exp_v) begin n_fail++; $display("FAIL small_read port %0d reg %0d: got %h expected %h", p, ad, bus_c.rd_data[p], exp_v); end
      end
      step();
    end
    // zero register and out-of-range reads, including a same-cycle write attempt
    bus_c.wr_en = 1'b1; bus_c.wr_addr[0] = 5'd23; bus_c.wr_data[0] = 32'hFFFF_FFFF;
    bus_c.rd_addr[0] = 5'd23; bus_c.rd_addr[1] = 5'd30; bus_c.rd_addr[2] = 5'd22;
    bus_c.rsv_en = 1'b1; bus_c.rsv_addr = 5'd30;
    #1;
    n_checks++; if (bus_c.rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL small_zero_read: got %h expected 0", bus_c.rd_data[0]); end
    n_checks++; if (bus_c.rd_data[1] !== 32'h0) begin n_fail++; $display("FAIL small_oor_read: got %h expected 0", bus_c.rd_data[1]); end
    step();
    bus_c.wr_en = 1'b0; bus_c.rsv_addr = 5'd23;
    #1;
    n_checks++; if (bus_c.busy_count !== 6'd0) begin n_fail++; $display("FAIL small_oor_rsv: got %0d expected 0", bus_c.busy_count); end
    step();
    bus_c.rsv_addr = 5'd22;
    #1;
    n_checks++; if (bus_c.busy_count !== 6'd0) begin n_fail++; $display("FAIL small_zero_rsv: got %0d expected 0", bus_c.busy_count); end
    step();
    bus_c.rsv_en = 1'b0;
    #1;
    n_checks++; if (bus_c.busy_count !== 6'd1) begin n_fail++; $display("FAIL small_rsv_count: got %0d expected 1", bus_c.busy_count); end
    n_checks++; if (bus_c.rd_busy !== 3'b100) begin n_fail++; $display("FAIL small_rd_busy: got %b expected 100", bus_c.rd_busy); end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
